// File: rtl/plic_pkg.sv
// Shared types and helpers for the PLIC hart arbiter.
// Round-robin tie-break is enabled by defining PLIC_ARB_RR_EN.
package plic_pkg;

  localparam int PLIC_NUM_IRQ  = 1024;
  localparam int PLIC_PRIO_BIT = 5;

  typedef logic [PLIC_PRIO_BIT-1:0]        prio_t;
  typedef logic [$clog2(PLIC_NUM_IRQ)-1:0] irq_id_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT,
    FLUSH
  } arb_state_e;

  function automatic int arb_num_steps(
    input int n,
    input int l
  );
    return (n + l - 1) / l;
  endfunction

endpackage

// File: rtl/plic_arb_lane_max.sv
// Combinational max-key reduction across one scan slice.
// Strict compare keeps the lowest lane index on ties.
module plic_arb_lane_max
  import plic_pkg::*;
#(
  parameter int LANES = 32,
  parameter int KW    = 6,
  parameter int LW    = 5
) (
  input  logic [LANES*KW-1:0] key_i,
  output logic [LW-1:0]       idx_o,
  output logic [KW-1:0]       key_o
);

  logic [KW-1:0] bk;
  logic [LW-1:0] bi;

  always_comb begin
    bk = '0;
    bi = '0;
    for (int j = 0; j < LANES; j++) begin
      if (key_i[j*KW +: KW] > bk) begin
        bk = key_i[j*KW +: KW];
        bi = LW'(j);
      end
    end
  end

  assign key_o = bk;
  assign idx_o = bi;

endmodule

// File: rtl/plic_hart_arb_sched.sv
// Per-context PLIC arbiter: iterative scan, commit, claim flush.
// Define PLIC_ARB_RR_EN for round-robin equal-priority tie-break.
module plic_hart_arb_sched
  import plic_pkg::*;
#(
  parameter int NUM_IRQ   = 1024,
  parameter int PRIO_BIT  = 5,
  parameter int ARB_LANES = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        arb_en_i,
  input  logic [NUM_IRQ-1:0]          irq_pending_i,
  input  logic [NUM_IRQ-1:0]          hart_int_en_i,
  input  logic [NUM_IRQ*PRIO_BIT-1:0] irq_prio_i,
  input  logic [PRIO_BIT-1:0]         hart_int_th_i,
  input  logic                        claim_i,
  output logic [$clog2(NUM_IRQ)-1:0]  winner_id_o,
  output logic [PRIO_BIT-1:0]         winner_prio_o,
  output logic                        eip_o,
  output logic                        scan_busy_o
);

  localparam int NSTEP = arb_num_steps(NUM_IRQ, ARB_LANES);
  localparam int IDW   = $clog2(NUM_IRQ);
  localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam int LW    = (ARB_LANES > 1) ? $clog2(ARB_LANES) : 1;
  localparam int KW    = PRIO_BIT + 1;
  localparam int PADW  = NSTEP * ARB_LANES;
  localparam int PW    = ARB_LANES * PRIO_BIT;
  localparam logic [SW-1:0] LAST = SW'(NSTEP - 1);

  arb_state_e    state;
  logic [SW-1:0] step;
  logic [IDW-1:0] best_id;
  logic [KW-1:0]  best_key;

  logic [PADW-1:0]          pend_pad;
  logic [PADW-1:0]          en_pad;
  logic [PADW*PRIO_BIT-1:0] prio_pad;

  logic [ARB_LANES-1:0] pend_s [NSTEP];
  logic [ARB_LANES-1:0] en_s   [NSTEP];
  logic [ARB_LANES-1:0] ok_s   [NSTEP];
  logic [PW-1:0]        prio_s [NSTEP];

  logic [ARB_LANES*KW-1:0] lane_key;
  logic [LW-1:0]           loc_idx;
  logic [KW-1:0]           loc_key;
  logic [IDW-1:0]          loc_id;

`ifdef PLIC_ARB_RR_EN
  logic [IDW-1:0] last_id;
`endif

  assign pend_pad = PADW'(irq_pending_i);
  assign en_pad   = PADW'(hart_int_en_i);
  assign prio_pad = (PADW*PRIO_BIT)'(irq_prio_i);

  // ID 0 and padding lanes past NUM_IRQ are never candidates
  for (genvar s = 0; s < NSTEP; s++) begin : g_step
    assign pend_s[s] = pend_pad[s*ARB_LANES +: ARB_LANES];
    assign en_s[s]   = en_pad[s*ARB_LANES +: ARB_LANES];
    assign prio_s[s] = prio_pad[s*PW +: PW];
    for (genvar j = 0; j < ARB_LANES; j++) begin : g_ok
      localparam int GID = s * ARB_LANES + j;
      assign ok_s[s][j] = (GID != 0) && (GID < NUM_IRQ);
    end
  end

  always_comb begin
    lane_key = '0;
    for (int j = 0; j < ARB_LANES; j++) begin
      logic [PRIO_BIT-1:0] p;
      logic                rr;
      p  = prio_s[step][j*PRIO_BIT +: PRIO_BIT];
      rr = 1'b0;
`ifdef PLIC_ARB_RR_EN
      rr = (int'(step) * ARB_LANES + j) > int'(last_id);
`endif
      if (pend_s[step][j] && en_s[step][j] &&
          ok_s[step][j] && (p != '0))
        lane_key[j*KW +: KW] = {p, rr};
    end
  end

  plic_arb_lane_max #(
    .LANES (ARB_LANES),
    .KW    (KW),
    .LW    (LW)
  ) u_lane_max (
    .key_i (lane_key),
    .idx_o (loc_idx),
    .key_o (loc_key)
  );

  assign loc_id = IDW'(int'(step) * ARB_LANES + int'(loc_idx));

  assign scan_busy_o = (state != IDLE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= IDLE;
      step          <= '0;
      best_id       <= '0;
      best_key      <= '0;
      winner_id_o   <= '0;
      winner_prio_o <= '0;
      eip_o         <= 1'b0;
`ifdef PLIC_ARB_RR_EN
      last_id       <= '0;
`endif
    end else if (!arb_en_i) begin
      state         <= IDLE;
      step          <= '0;
      best_id       <= '0;
      best_key      <= '0;
      winner_id_o   <= '0;
      winner_prio_o <= '0;
      eip_o         <= 1'b0;
    end else if (claim_i && state != IDLE) begin
      // claim beats a coincident commit
      state         <= FLUSH;
      step          <= '0;
      best_id       <= '0;
      best_key      <= '0;
      winner_id_o   <= '0;
      winner_prio_o <= '0;
      eip_o         <= 1'b0;
`ifdef PLIC_ARB_RR_EN
      last_id       <= winner_id_o;
`endif
    end else begin
      eip_o <= (winner_prio_o > hart_int_th_i);
      case (state)
        IDLE: begin
          state <= SCAN;
          step  <= '0;
        end
        SCAN: begin
          if (loc_key > best_key) begin
            best_key <= loc_key;
            best_id  <= loc_id;
          end
          if (step == LAST) begin
            step  <= '0;
            state <= COMMIT;
          end else begin
            step <= step + SW'(1);
          end
        end
        COMMIT: begin
          winner_id_o   <= best_id;
          winner_prio_o <= best_key[KW-1:1];
          best_id       <= '0;
          best_key      <= '0;
          step          <= '0;
          state         <= SCAN;
        end
        FLUSH: begin
          step  <= '0;
          state <= SCAN;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plic_hart_arb_sched.sv
// Bench for plic_hart_arb_sched: 64-source and 40-source instances
// share stimulus and are checked against a max-search reference.
module tb_plic_hart_arb_sched;

  localparam int PB = 5;
`ifdef PLIC_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          arb_en;
  logic          claim;
  logic [PB-1:0] th;
  logic [63:0]   pend;
  logic [63:0]   en;
  logic [64*PB-1:0] prio;

  logic [5:0]    wid64, wid40;
  logic [PB-1:0] wpr64, wpr40;
  logic          eip64, eip40;
  logic          bsy64, bsy40;

  int pr [64];
  bit pd [64];
  bit ee [64];

  int vectors = 0;
  int miscompares = 0;
  int exp_id64, exp_p64, exp_id40, exp_p40;
  int last64, last40;

  always #5 clk = ~clk;

  plic_hart_arb_sched #(
    .NUM_IRQ (64), .PRIO_BIT (PB), .ARB_LANES (32)
  ) u_dut64 (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .arb_en_i      (arb_en),
    .irq_pending_i (pend),
    .hart_int_en_i (en),
    .irq_prio_i    (prio),
    .hart_int_th_i (th),
    .claim_i       (claim),
    .winner_id_o   (wid64),
    .winner_prio_o (wpr64),
    .eip_o         (eip64),
    .scan_busy_o   (bsy64)
  );

  plic_hart_arb_sched #(
    .NUM_IRQ (40), .PRIO_BIT (PB), .ARB_LANES (32)
  ) u_dut40 (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .arb_en_i      (arb_en),
    .irq_pending_i (pend[39:0]),
    .hart_int_en_i (en[39:0]),
    .irq_prio_i    (prio[40*PB-1:0]),
    .hart_int_th_i (th),
    .claim_i       (claim),
    .winner_id_o   (wid40),
    .winner_prio_o (wpr40),
    .eip_o         (eip40),
    .scan_busy_o   (bsy40)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: highest key among candidates, earliest ID on ties
  function automatic void ref_win(input int n, input int last,
                                  output int id, output int p);
    int bk;
    int k;
    bk = 0;
    id = 0;
    p  = 0;
    for (int i = 1; i < n; i++) begin
      if (pd[i] && ee[i] && pr[i] != 0) begin
        k = pr[i] * 2 + ((RR && i > last) ? 1 : 0);
        if (k > bk) begin
          bk = k;
          id = i;
          p  = pr[i];
        end
      end
    end
  endfunction

  task automatic apply();
    for (int i = 0; i < 64; i++) begin
      pend[i] = pd[i];
      en[i]   = ee[i];
      prio[i*PB +: PB] = PB'(pr[i]);
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < 64; i++) begin
      pd[i] = 1'b0;
      ee[i] = 1'b0;
      pr[i] = 0;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_id64"}, 32'(wid64), 0);
    chk({tag, "_pr64"}, 32'(wpr64), 0);
    chk({tag, "_eip64"}, 32'(eip64), 0);
    chk({tag, "_id40"}, 32'(wid40), 0);
    chk({tag, "_pr40"}, 32'(wpr40), 0);
    chk({tag, "_eip40"}, 32'(eip40), 0);
  endtask

  task automatic chk_win(input string tag);
    ref_win(64, last64, exp_id64, exp_p64);
    ref_win(40, last40, exp_id40, exp_p40);
    chk({tag, "_id64"}, 32'(wid64), 32'(exp_id64));
    chk({tag, "_pr64"}, 32'(wpr64), 32'(exp_p64));
    chk({tag, "_id40"}, 32'(wid40), 32'(exp_id40));
    chk({tag, "_pr40"}, 32'(wpr40), 32'(exp_p40));
  endtask

  task automatic chk_eip(input string tag);
    chk({tag, "_eip64"}, 32'(eip64), 32'(exp_p64 > int'(th)));
    chk({tag, "_eip40"}, 32'(eip40), 32'(exp_p40 > int'(th)));
  endtask

  task automatic claim_pulse();
    last64   = exp_id64;
    last40   = exp_id40;
    exp_id64 = 0;
    exp_id40 = 0;
    exp_p64  = 0;
    exp_p40  = 0;
    claim = 1'b1;
    tick(1);
    claim = 1'b0;
  endtask

  // Claim, then require exact flush-to-commit latency
  task automatic do_claim(input string tag);
    claim_pulse();
    chk_zero({tag, "_clr"});
    chk({tag, "_busy"}, 32'(bsy64 & bsy40), 1);
    tick(3);
    chk({tag, "_early64"}, 32'(wid64), 0);
    chk({tag, "_early40"}, 32'(wid40), 0);
    tick(1);
    chk_win(tag);
    tick(1);
    chk_eip(tag);
  endtask

  initial begin
    rst_n  = 1'b0;
    arb_en = 1'b0;
    claim  = 1'b0;
    th     = '0;
    exp_id64 = 0; exp_p64 = 0;
    exp_id40 = 0; exp_p40 = 0;
    last64 = 0; last40 = 0;
    clear_src();
    apply();
    tick(2);
    chk_zero("rst");
    chk("rst_busy", 32'(bsy64 | bsy40), 0);
    rst_n = 1'b1;
    tick(1);

    // single source, threshold 0
    pd[5] = 1; ee[5] = 1; pr[5] = 3;
    apply();
    arb_en = 1'b1;
    tick(3);
    chk("t1_early", 32'(wid64 | wid40), 0);
    tick(1);
    chk_win("t1");
    chk("t1_eip_lat", 32'(eip64), 0);
    tick(1);
    chk_eip("t1");
    chk("t1_eip64", 32'(eip64), 1);

    // equal priority tie
    clear_src();
    pd[7] = 1; ee[7] = 1; pr[7] = 4;
    pd[40] = 1; ee[40] = 1; pr[40] = 4;
    apply();
    do_claim("t2a");
    chk("t2a_id", 32'(wid64), 7);
    do_claim("t2b");
    chk("t2b_id", 32'(wid64), RR ? 40 : 7);
    chk("t2b_id40", 32'(wid40), 7);

    // threshold boundary
    clear_src();
    pd[9] = 1; ee[9] = 1; pr[9] = 2;
    apply();
    do_claim("t3");
    chk("t3_eip_hi", 32'(eip64), 1);
    th = 5'd2;
    tick(1);
    chk_eip("t3_eq");
    chk("t3_eq_eip", 32'(eip64), 0);
    th = 5'd1;
    tick(1);
    chk_eip("t3_gt");
    chk("t3_gt_eip", 32'(eip64), 1);
    th = 5'd0;
    pr[9] = 1;
    apply();
    do_claim("t3_p1");
    chk("t3_p1_eip", 32'(eip64), 1);

    // claim lands on scan step 1 here
    do_claim("t4");

    // claim coincident with commit
    claim_pulse();
    tick(3);
    do_claim("t5_cc");

    // disable mid-scan, claim ignored while disabled
    tick(1);
    arb_en = 1'b0;
    tick(1);
    exp_id64 = 0; exp_id40 = 0; exp_p64 = 0; exp_p40 = 0;
    chk_zero("t5_dis");
    chk("t5_dis_busy", 32'(bsy64 | bsy40), 0);
    claim = 1'b1;
    tick(1);
    claim = 1'b0;
    chk("t5_dis_clm", 32'(bsy64 | bsy40), 0);
    arb_en = 1'b1;
    tick(3);
    chk("t5_re_early", 32'(wid64 | wid40), 0);
    tick(1);
    chk_win("t5_re");
    tick(1);
    chk_eip("t5_re");

    // top ID wins, ID 0 never wins
    clear_src();
    pd[0] = 1; ee[0] = 1; pr[0] = 31;
    pd[39] = 1; ee[39] = 1; pr[39] = 31;
    pd[50] = 1; ee[50] = 1; pr[50] = 31;
    apply();
    do_claim("t6");
    chk("t6_id40", 32'(wid40), 39);
    chk("t6_pr40", 32'(wpr40), 31);

    // randomized sweep
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 64; i++) begin
        pd[i] = ($urandom_range(0, 3) == 0);
        ee[i] = ($urandom_range(0, 3) != 0);
        pr[i] = (it % 2 == 1) ? int'($urandom_range(0, 3))
                              : int'($urandom_range(0, 31));
      end
      th = PB'($urandom_range(0, 4));
      apply();
      do_claim("rnd");
    end

    // asynchronous reset mid-scan
    tick(1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("arst");
    chk("arst_busy", 32'(bsy64 | bsy40), 0);
    tick(1);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
